// File: rtl/gray_bcd_pkg.sv
// gray_bcd_pkg: shared state type and constants for the Gray-to-BCD deframer
package gray_bcd_pkg;
    typedef enum logic {COLLECT, HOLD} state_t;
    localparam logic [3:0] BCD_BAD    = 4'hF;
    localparam logic [7:0] ERRCNT_MAX = 8'd255;
endpackage

// File: rtl/gray_digit_dec.sv
// gray_digit_dec: combinational binary-reflected Gray to BCD digit decoder
//   gray : Gray-coded digit in
//   bcd  : decoded digit, BCD_BAD when the code decodes above 9
//   bad  : code decodes to 10..15
module gray_digit_dec
    import gray_bcd_pkg::*;
(
    input  logic [3:0] gray,
    output logic [3:0] bcd,
    output logic       bad
);
    logic [3:0] b;
    assign b   = {gray[3], ^gray[3:2], ^gray[3:1], ^gray};
    assign bad = b > 4'd9;
    assign bcd = bad ? BCD_BAD : b;
endmodule

// File: rtl/gray_bcd_deframer.sv
// gray_bcd_deframer: packs DIGITS Gray-coded digits (MSD first) into a BCD word
//   clk, rst_n          : clock, async active-low reset
//   flush               : drop the partially collected word (ignored while holding)
//   in_valid/in_ready   : digit handshake, in_gray carries the Gray digit
//   out_valid/out_ready : word handshake, out_bcd (digit 0 in top nibble), out_err
//   err_cnt             : saturating invalid-digit count, built only with GRAY_BCD_ERRCNT_EN
module gray_bcd_deframer
    import gray_bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [3:0]          in_gray,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [4*DIGITS-1:0] out_bcd,
    output logic                out_err,
    output logic [7:0]          err_cnt
);
    localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    state_t state, state_nx;
    logic [CW-1:0] cnt;
    logic [4*DIGITS-1:0] word;
    logic [4*DIGITS+3:0] wide;
    logic [3:0] dig;
    logic bad, err, take, last;

    gray_digit_dec u_dec (
        .gray (in_gray),
        .bcd  (dig),
        .bad  (bad)
    );

    // flush beats a simultaneous digit, so it is never taken
    assign take = in_valid && state == COLLECT && !flush;
    assign last = cnt == CW'(DIGITS - 1);
    // appending below the old word keeps the first digit in the top nibble
    assign wide = {word, dig};

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= COLLECT;
        else        state <= state_nx;

    always_comb begin
        state_nx = state;
        state_nx = (state == COLLECT) ? ((take && last) ? HOLD : COLLECT)
                                      : (out_ready ? COLLECT : HOLD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            word <= '0;
            err  <= 1'b0;
        end else if (state == COLLECT) begin
            if (flush) begin
                cnt  <= '0;
                word <= '0;
                err  <= 1'b0;
            end else if (take) begin
                word <= wide[4*DIGITS-1:0];
                err  <= err | bad;
                cnt  <= last ? '0 : cnt + CW'(1);
            end
        end else if (out_ready) begin
            err <= 1'b0;
        end
    end

    assign in_ready  = state == COLLECT;
    assign out_valid = state == HOLD;
    assign out_bcd   = word;
    assign out_err   = err;

`ifdef GRAY_BCD_ERRCNT_EN
    logic [7:0] ecnt;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)                                ecnt <= 8'd0;
        else if (take && bad && ecnt != ERRCNT_MAX) ecnt <= ecnt + 8'd1;
    assign err_cnt = ecnt;
`else
    assign err_cnt = 8'd0;
`endif
endmodule

// File: tb/tb_gray_bcd_deframer.sv
// tb_gray_bcd_deframer: scoreboard bench for gray_bcd_deframer (DIGITS=4)
module tb_gray_bcd_deframer;
`ifdef GRAY_BCD_ERRCNT_EN
    localparam bit EN = 1'b1;
`else
    localparam bit EN = 1'b0;
`endif
    logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
    logic [3:0] in_gray = 4'd0;
    logic in_ready, out_valid, out_err;
    logic [15:0] out_bcd;
    logic [7:0] err_cnt;
    logic [16:0] q[$];
    int checks = 0, errors = 0;

    gray_bcd_deframer #(.DIGITS(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_gray   (in_gray),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bcd   (out_bcd),
        .out_err   (out_err),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h req=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] g);
        in_valid = 1'b1;
        in_gray  = g;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic word(input logic [15:0] g, input logic [15:0] eb, input logic ee);
        q.push_back({eb, ee});
        for (int i = 3; i >= 0; i--) send(g[4*i +: 4]);
        chk("latency_valid", out_valid, 1);
        chk("hold_in_ready", in_ready, 0);
    endtask

    initial forever begin
        @(negedge clk);
        if (rst_n && out_valid && out_ready) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word act=%h req=none", out_bcd);
            end else begin
                logic [16:0] e;
                e = q.pop_front();
                chk("word_bcd", out_bcd, e[16:1]);
                chk("word_err", out_err, e[0]);
            end
        end
    end

    initial begin
        #2;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_bcd", out_bcd, 0);
        chk("rst_out_err", out_err, 0);
        chk("rst_err_cnt", err_cnt, 0);
        tick();
        rst_n = 1'b1;
        tick();

        word(16'h26CD, 16'h3489, 1'b0);
        tick();
        chk("one_cycle_valid", out_valid, 0);
        chk("ready_back", in_ready, 1);

        word(16'h0F13, 16'h0F12, 1'b1);
        chk("err_cnt_one", err_cnt, EN ? 1 : 0);
        tick();

        out_ready = 1'b0;
        word(16'h0132, 16'h0123, 1'b0);
        for (int i = 0; i < 5; i++) begin
            chk("stall_in_ready", in_ready, 0);
            chk("stall_valid", out_valid, 1);
            chk("stall_bcd", out_bcd, 16'h0123);
            tick();
        end
        out_ready = 1'b1;
        tick();
        chk("stall_release_ready", in_ready, 1);
        chk("stall_release_valid", out_valid, 0);

        send(4'hF);
        send(4'h1);
        in_valid = 1'b1;
        in_gray  = 4'hA;
        flush    = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_no_word", out_valid, 0);
        chk("flush_err_cnt", err_cnt, EN ? 2 : 0);
        word(16'h547C, 16'h6758, 1'b0);
        tick();

        send(4'hF);
        send(4'hD);
        send(4'hC);
        rst_n = 1'b0;
        #2;
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_bcd", out_bcd, 0);
        chk("mid_rst_err", out_err, 0);
        chk("mid_rst_err_cnt", err_cnt, 0);
        tick();
        rst_n = 1'b1;
        tick();
        word(16'h7654, 16'h5467, 1'b0);
        tick();

        for (int i = 0; i < 75; i++) begin
            word(16'hAAAA, 16'hFFFF, 1'b1);
            tick();
        end
        chk("sat_err_cnt", err_cnt, EN ? 255 : 0);
        send(4'hA);
        chk("sat_hold", err_cnt, EN ? 255 : 0);
        in_valid = 1'b1;
        flush    = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("sat_after_flush", err_cnt, EN ? 255 : 0);
        repeat (3) tick();
        chk("queue_empty", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/gray_bcd_deframer.md
# gray_bcd_deframer

Receive-side counterpart of the BCD-to-Gray encoder. Accepts a stream of 4-bit Gray-coded decimal digits, most significant digit first, over a valid/ready handshake. Decodes each digit to BCD, flags codes outside 0–9, and packs DIGITS digits into one BCD word. Presents each word on a registered valid/ready output. Sits between the Gray-coded digit link and the BCD display/arithmetic path.

## Interface
- DIGITS, 4: digits per output word (1–8).
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous; discards the partially collected word.
- in_valid  in  1  in_gray carries a digit.
- in_ready  out  1  block accepts the digit this cycle.
- in_gray  in  4  Gray-coded digit.
- out_valid  out  1  out_bcd/out_err hold a complete word.
- out_ready  in  1  downstream accepts the word.
- out_bcd  out  4*DIGITS  packed BCD word; digit 0 (first received) is in the top nibble.
- out_err  out  1  at least one digit in the word was invalid.
- err_cnt  out  8  count of invalid digits (see Configuration).

## Operation
- Gray decode uses the binary-reflected code: b3=g3, b2=b3^g2, b1=b2^g1, b0=b1^g0.
  - Valid codes map as: 0000→0, 0001→1, 0011→2, 0010→3, 0110→4, 0111→5, 0101→6, 0100→7, 1100→8, 1101→9.
  - Any code decoding to 10–15 is invalid, including 1111, which is the encoder's error code.
  - An invalid digit is stored as 4'hF and sets the word's sticky error flag.
- The FSM has two states, COLLECT and HOLD.
- COLLECT:
  - in_ready=1.
  - On a transfer (in_valid & in_ready), the decoded digit is shifted into the word register and the digit counter increments.
  - When the counter reaches DIGITS-1 and a transfer occurs: the word is complete, the counter resets to 0, and the FSM goes to HOLD.
- HOLD:
  - in_ready=0 and out_valid=1.
  - out_bcd/out_err are stable until out_ready=1; the FSM then returns to COLLECT and the error flag clears.
- flush in COLLECT:
  - Clears the counter, the word register, and the sticky error flag.
  - A digit presented in the same cycle is dropped, and flush wins.
  - err_cnt still counts an invalid digit that was presented and accepted in that cycle; with flush active it is not accepted, so it is not counted.
- flush in HOLD: ignored; the held word is not lost.
- Reset mid-word discards all partial state.

## Timing
- Reset values: in_ready=1, out_valid=0, out_bcd=0, out_err=0, err_cnt=0, state=COLLECT, counter=0.
- Latency: out_valid rises on the cycle after the last digit transfer.
- Words flow back-to-back with one dead input cycle per word:
  - Throughput is DIGITS digits per DIGITS+1 cycles when out_ready is held high.
  - in_ready returns to 1 on the cycle after the output transfer.
- in_ready is a registered function of state only; it has no combinational path from out_ready.
- out_valid holds its value while out_ready=0, and all outputs are stable while stalled.

## Configuration
- GRAY_BCD_ERRCNT_EN defined:
  - err_cnt is an 8-bit counter that increments once per accepted invalid digit.
  - It saturates at 255.
  - It is cleared only by rst_n; flush does not clear it.
- GRAY_BCD_ERRCNT_EN undefined:
  - No counter logic is built.
  - err_cnt is driven constant 0.
  - The port remains present.

## Structure
- Shared package gray_bcd_pkg contains:
  - The state enum (COLLECT, HOLD).
  - The constant BCD_BAD = 4'hF.
  - The constant ERRCNT_MAX = 8'd255.
- One sub-module, gray_digit_dec: combinational; inputs gray[3:0]; outputs bcd[3:0] and bad. All sequencing stays in the top module.

## Test plan
- Reset with DIGITS=4, then send 0010,0110,1100,1101 with out_ready=1 → out_bcd=16'h3489, out_err=0, out_valid for 1 cycle, 1 cycle after the 4th transfer.
- Send 0000,1111,0001,0011 → out_bcd=16'h0F12, out_err=1; err_cnt=1 with the macro, 0 without.
- Hold out_ready=0 for 5 cycles after a word completes → in_ready=0 and out_bcd stable throughout; word delivered when out_ready rises; in_ready=1 the next cycle.
- Send 2 digits, assert flush together with a 3rd in_valid, then send 0101,0100,0111,1100 → output 16'h6758; the flushed digits and the dropped digit never appear.
- Assert rst_n low mid-word after 3 digits → all outputs at reset values; the next 4 digits form a clean word.
- With the macro, send 300 invalid digits (1010) → err_cnt saturates at 255 and stays there; flush does not change it.
